// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: first-word-fall-through byte FIFO feeding the UART TX controller.
// Optional sticky overflow flag: define UART_TX_FIFO_STICKY_OVF_EN.
module uart_tx_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH_LOG2   = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                  Clk,
  input  logic                  Resetn,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_ready,
`ifdef UART_TX_FIFO_STICKY_OVF_EN
  input  logic                  ovf_clr,
  output logic                  ovf_sticky,
`endif
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;

  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_AF   = LW'(AFULL_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [LW-1:0]         level_nxt;
  logic                  push;
  logic                  pop;
  logic                  drop;

  assign pop     = rd_valid && rd_ready;
  assign push    = wr_en && (!full || pop);
  assign drop    = wr_en && full && !pop;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    level_nxt = level;
    unique case ({push, pop})
      2'b10:   level_nxt = level + LW'(1);
      2'b01:   level_nxt = level - LW'(1);
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Flags come from level_nxt so they move in the same cycle as level.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      rd_valid    <= 1'b0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level       <= level_nxt;
      rd_valid    <= (level_nxt != '0);
      empty       <= (level_nxt == '0);
      full        <= (level_nxt == LVL_FULL);
      almost_full <= (level_nxt >= LVL_AF);
      overflow    <= drop;
    end
  end

`ifdef UART_TX_FIFO_STICKY_OVF_EN
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn)      ovf_sticky <= 1'b0;
    else if (drop)    ovf_sticky <= 1'b1;
    else if (ovf_clr) ovf_sticky <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: queue-model bench for uart_tx_fifo with a behavioural
// UART transmit controller on the read side.
module tb_uart_tx_fifo;

  logic       Clk = 1'b0;
  logic       Resetn = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       tb_ready = 1'b0;
  logic       rd_ready;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic [4:0] level;
  logic       overflow;
`ifdef UART_TX_FIFO_STICKY_OVF_EN
  logic       ovf_clr = 1'b0;
  logic       ovf_sticky;
`endif

  logic ctl_mode = 1'b0;
  logic ctl_ready = 1'b1;
  logic txd = 1'b1;

  int total = 0;
  int bad = 0;
  bit chk_en = 0;

  assign rd_ready = ctl_mode ? ctl_ready : tb_ready;

  always #5 Clk = ~Clk;

  uart_tx_fifo dut (
    .Clk(Clk),
    .Resetn(Resetn),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .rd_ready(rd_ready),
`ifdef UART_TX_FIFO_STICKY_OVF_EN
    .ovf_clr(ovf_clr),
    .ovf_sticky(ovf_sticky),
`endif
    .rd_valid(rd_valid),
    .rd_data(rd_data),
    .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .level(level),
    .overflow(overflow)
  );

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  // Reference model: a plain queue of at most 16 bytes.
  logic [7:0] q[$];
  int  pops = 0;
  bit  m_ovf = 0;
  bit  m_sticky = 0;
  bit  m_pop, m_push, m_drop;

  always @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      q.delete();
      m_ovf = 0;
      m_sticky = 0;
    end else begin
      m_pop  = (q.size() > 0) && rd_ready;
      m_push = wr_en && (q.size() < 16 || m_pop);
      m_drop = wr_en && q.size() == 16 && !m_pop;
      if (m_pop) begin
        void'(q.pop_front());
        pops++;
      end
      if (m_push) q.push_back(wr_data);
      m_ovf = m_drop;
`ifdef UART_TX_FIFO_STICKY_OVF_EN
      if (m_drop) m_sticky = 1;
      else if (ovf_clr) m_sticky = 0;
`endif
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      check("level", level, q.size());
      check("rd_valid", rd_valid, q.size() != 0);
      check("empty", empty, q.size() == 0);
      check("full", full, q.size() == 16);
      check("almost_full", almost_full, q.size() >= 12);
      check("overflow", overflow, m_ovf);
      if (q.size() > 0) check("rd_data", rd_data, q[0]);
`ifdef UART_TX_FIFO_STICKY_OVF_EN
      check("ovf_sticky", ovf_sticky, m_sticky);
`endif
    end
  end

  // Transmit controller: Ready high when idle, 16 ticks per bit, 8N1.
  logic [7:0] ctl_byte;
  logic [9:0] frame;
  always begin
    @(posedge Clk);
    if (ctl_mode && ctl_ready && rd_valid) begin
      ctl_byte = rd_data;
      #1 ctl_ready = 1'b0;
      frame = {1'b1, ctl_byte, 1'b0};
      for (int b = 0; b < 10; b++) begin
        txd = frame[b];
        repeat (16) @(posedge Clk);
        #1;
      end
      ctl_ready = 1'b1;
    end
  end

  task automatic rx_byte(output logic [7:0] b);
    int t;
    b = 8'h00;
    t = 0;
    while (txd !== 1'b0 && t < 400) begin
      @(negedge Clk);
      t++;
    end
    check("rx_start_seen", t < 400, 1);
    repeat (8) @(negedge Clk);
    check("rx_start_bit", txd, 0);
    for (int i = 0; i < 8; i++) begin
      repeat (16) @(negedge Clk);
      b[i] = txd;
    end
    repeat (16) @(negedge Clk);
    check("rx_stop_bit", txd, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  logic [7:0] rx [3];
  logic [7:0] exp_b;
  int pops0;

  initial begin
    #2 Resetn = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Resetn = 1'b1;
    check("rst_level", level, 0);
    check("rst_empty", empty, 1);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_full", full, 0);
    check("rst_af", almost_full, 0);
    check("rst_ovf", overflow, 0);
`ifdef UART_TX_FIFO_STICKY_OVF_EN
    check("rst_sticky", ovf_sticky, 0);
`endif
    chk_en = 1;

    // 1: single push, FWFT latency
    wr_en = 1'b1; wr_data = 8'h55;
    cyc();
    wr_en = 1'b0;
    check("t1_valid", rd_valid, 1);
    check("t1_data", rd_data, 8'h55);
    check("t1_level", level, 1);
    check("t1_empty", empty, 0);
    tb_ready = 1'b1;
    cyc();
    tb_ready = 1'b0;
    check("t1_drained", empty, 1);

    // 2: fill to full, then drop
    for (int i = 1; i <= 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      cyc();
      if (i == 11) check("t2_af_11", almost_full, 0);
      if (i == 12) check("t2_af_12", almost_full, 1);
      if (i == 15) check("t2_full_15", full, 0);
    end
    check("t2_full", full, 1);
    check("t2_level", level, 16);
    wr_data = 8'hAA;
    cyc();
    check("t2_ovf", overflow, 1);
    check("t2_lvl_drop", level, 16);
    wr_en = 1'b0;
    cyc();
    check("t2_ovf_pulse", overflow, 0);
    check("t2_head", rd_data, 8'h01);

    // 3: push and pop while full
    wr_en = 1'b1; wr_data = 8'hBB; tb_ready = 1'b1;
    cyc();
    wr_en = 1'b0;
    check("t3_level", level, 16);
    check("t3_ovf", overflow, 0);
    for (int i = 0; i < 16; i++) begin
      exp_b = (i < 15) ? 8'(i + 2) : 8'hBB;
      check("t3_drain", rd_data, exp_b);
      cyc();
    end
    tb_ready = 1'b0;
    check("t3_empty", empty, 1);

    // 4: UART controller on the read side
    ctl_mode = 1'b1;
    pops0 = pops;
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          wr_en = 1'b1; wr_data = 8'(8'h41 + i);
          cyc();
        end
        wr_en = 1'b0;
      end
      begin
        for (int i = 0; i < 3; i++) rx_byte(rx[i]);
      end
    join
    check("t4_rx0", rx[0], 8'h41);
    check("t4_rx1", rx[1], 8'h42);
    check("t4_rx2", rx[2], 8'h43);
    repeat (20) cyc();
    check("t4_pops", pops - pops0, 3);
    check("t4_valid", rd_valid, 0);
    ctl_mode = 1'b0;

    // 5: steady push/pop at low level, pointers wrap
    wr_en = 1'b1; wr_data = 8'hA0;
    cyc();
    wr_data = 8'hA1;
    cyc();
    tb_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wr_data = 8'(8'hA2 + i);
      cyc();
    end
    wr_en = 1'b0; tb_ready = 1'b0;
    check("t5_level", level, 2);
    check("t5_head", rd_data, 8'hB4);
    tb_ready = 1'b1;
    cyc();
    check("t5_next", rd_data, 8'hB5);
    cyc();
    tb_ready = 1'b0;

    // 6: async reset during a pop at level 7
    for (int i = 0; i < 7; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'hC0 + i);
      cyc();
    end
    wr_en = 1'b0;
    check("t6_level7", level, 7);
    tb_ready = 1'b1;
    #3 Resetn = 1'b0;
    #1;
    check("t6_level", level, 0);
    check("t6_empty", empty, 1);
    check("t6_valid", rd_valid, 0);
    @(posedge Clk);
    #1 Resetn = 1'b1;
    tb_ready = 1'b0;
    cyc();

`ifdef UART_TX_FIFO_STICKY_OVF_EN
    check("t6_sticky_rst", ovf_sticky, 0);
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      cyc();
    end
    wr_en = 1'b0;
    check("t6_sticky_set", ovf_sticky, 1);
    repeat (3) cyc();
    check("t6_sticky_hold", ovf_sticky, 1);
    wr_en = 1'b1; ovf_clr = 1'b1;
    cyc();
    wr_en = 1'b0;
    check("t6_sticky_setwins", ovf_sticky, 1);
    cyc();
    ovf_clr = 1'b0;
    check("t6_sticky_clr", ovf_sticky, 0);
    tb_ready = 1'b1;
    repeat (16) cyc();
    tb_ready = 1'b0;
`endif

    cyc();
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
